// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-memory responder.
package dmem_pkg;
    localparam int DATA_W    = 64;
    localparam int DEF_DEPTH = 1024;
    localparam int DEF_AW    = 14;

    typedef enum logic [1:0] {CLEAR, RUN, DUMP, DONE} state_t;
endpackage

// File: rtl/dmem_if.sv
// Valid/ready stream carrying the memory image out after halt.
interface dmem_if;
    import dmem_pkg::*;

    logic              valid;
    logic              ready;
    logic [31:0]       addr;
    logic [DATA_W-1:0] data;

    modport master (output valid, output addr, output data, input ready);
    modport slave  (input valid, input addr, input data, output ready);
endinterface

// File: rtl/dmem_array.sv
// Word array: one synchronous write port, two asynchronous read ports.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int IW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IW-1:0]     bus_raddr,
    output logic [DATA_W-1:0] bus_rdata,
    input  logic [IW-1:0]     dump_raddr,
    output logic [DATA_W-1:0] dump_rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign bus_rdata  = mem[bus_raddr];
    assign dump_rdata = mem[dump_raddr];
endmodule

// File: rtl/dmem_responder.sv
// Data-bus memory responder: clears on reset, serves loads/stores,
// then streams the image with an XOR checksum once the core halts.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = DEF_AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [63:0]       addr,
    input  logic              mem_rw,
    inout  wire  [DATA_W-1:0] mem_data,
    input  logic              halt,
    output logic              mem_ready,
    output logic              oob_err,
    dmem_if.master            dump,
    output logic              dump_done,
    output logic [DATA_W-1:0] dump_checksum
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;

    state_t            state;
    logic [CW-1:0]     clr_idx;
    logic [CW-1:0]     dump_idx;
    logic              in_range;
    logic [IW-1:0]     bus_idx;
    logic              we;
    logic [IW-1:0]     waddr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] bus_rdata;
    logic [DATA_W-1:0] dump_rdata;

    // Upper address bits must be zero; compare covers all 64 bits.
    assign in_range = (addr[63:AW] == '0) &&
                      (64'(addr[AW-1:3]) < 64'(DEPTH));
    assign bus_idx  = addr[IW+2:3];

    always_comb begin
        we    = 1'b0;
        waddr = bus_idx;
        wdata = mem_data;
        if (rst) begin
            if (state == CLEAR) begin
                we    = 1'b1;
                waddr = clr_idx[IW-1:0];
                wdata = '0;
            end else if (state == RUN) begin
                we = mem_rw && in_range;
            end
        end
    end

    dmem_array #(.DEPTH(DEPTH), .IW(IW)) u_array (
        .clk        (clk),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata),
        .bus_raddr  (bus_idx),
        .bus_rdata  (bus_rdata),
        .dump_raddr (dump_idx[IW-1:0]),
        .dump_rdata (dump_rdata)
    );

    assign mem_data = (state == RUN && !mem_rw) ?
                      (in_range ? bus_rdata : '0) : 'z;

    assign dump.addr = dump.valid ? 32'(dump_idx) << 3 : '0;
    assign dump.data = dump.valid ? dump_rdata : '0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= CLEAR;
            clr_idx       <= '0;
            dump_idx      <= '0;
            dump_checksum <= '0;
            oob_err       <= 1'b0;
            mem_ready     <= 1'b0;
            dump.valid    <= 1'b0;
            dump_done     <= 1'b0;
        end else begin
            unique case (state)
                CLEAR: begin
                    clr_idx <= clr_idx + CW'(1);
                    if (clr_idx == CW'(DEPTH - 1)) begin
                        state     <= RUN;
                        mem_ready <= 1'b1;
                    end
                end
                RUN: begin
                    if (!in_range) begin
                        oob_err <= 1'b1;
                    end
                    if (halt) begin
                        state         <= DUMP;
                        mem_ready     <= 1'b0;
                        dump.valid    <= 1'b1;
                        dump_idx      <= '0;
                        dump_checksum <= '0;
                    end
                end
                DUMP: begin
                    if (dump.ready) begin
                        dump_checksum <= dump_checksum ^ dump.data;
                        dump_idx      <= dump_idx + CW'(1);
                        if (dump_idx == CW'(DEPTH - 1)) begin
                            state      <= DONE;
                            dump.valid <= 1'b0;
                            dump_done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                end
            endcase
        end
    end
endmodule
